// File: rtl/snn_pkg.sv
// Shared SNN constants and the image-loader state encoding.
package snn_pkg;
  localparam int NUM_BYTES = 98;
  localparam int NUM_PIX   = NUM_BYTES * 8;
  localparam int ADDR_W    = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UNPACK    = 2'd1,
    START     = 2'd2,
    WAIT_CORE = 2'd3
  } loader_state_t;
endpackage

// File: rtl/snn_image_loader_if.sv
// Loader-facing signals: UART byte in, input-RAM write port, core handshake.
interface snn_image_loader_if #(parameter int ADDR_W = snn_pkg::ADDR_W);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              core_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic              ram_sel;
  logic              core_start;
  logic              busy;
  logic              overrun;

  modport slave (
    input  rx_rdy, rx_data, core_done,
    output ram_we, ram_addr, ram_wdata, ram_sel, core_start, busy, overrun
  );

  modport master (
    output rx_rdy, rx_data, core_done,
    input  ram_we, ram_addr, ram_wdata, ram_sel, core_start, busy, overrun
  );
endinterface

// File: rtl/snn_image_loader_byte_unpacker.sv
// Shift register, bit counter and one-byte holding buffer for the image loader.
module byte_unpacker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy_i,
  input  logic [7:0] rx_data_i,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       capture_i,
  output logic       byte_valid_o,
  output logic       bit_out_o,
  output logic       last_bit_o,
  output logic       drop_o
);
  logic [7:0] shift_q, shift_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  assign byte_valid_o = buf_full_q | rx_rdy_i;
  assign bit_out_o    = shift_q[0];
  assign last_bit_o   = (bit_cnt_q == 3'd7);

  always_comb begin
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bit_cnt_d  = bit_cnt_q;
    drop_o     = 1'b0;
    if (shift_i) begin
      shift_d   = {1'b0, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // A load drains the buffer first; a byte arriving that same cycle refills it.
    if (load_i) begin
      bit_cnt_d = '0;
      if (buf_full_q) begin
        shift_d    = buf_q;
        buf_full_d = rx_rdy_i;
        if (rx_rdy_i) buf_d = rx_data_i;
      end else begin
        shift_d = rx_data_i;
      end
    end else if (rx_rdy_i) begin
      if (capture_i && !buf_full_q) begin
        buf_d      = rx_data_i;
        buf_full_d = 1'b1;
      end else begin
        drop_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/snn_image_loader.sv
// Unpacks UART bytes into 1-bit input-RAM writes and kicks snn_core per full image.
module snn_image_loader #(
  parameter int NUM_BYTES = snn_pkg::NUM_BYTES,
  parameter int ADDR_W    = snn_pkg::ADDR_W
) (
  input logic               clk,
  input logic               rst_n,
  snn_image_loader_if.slave bus
);
  import snn_pkg::*;

  localparam int                NUM_PIX  = NUM_BYTES * 8;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [6:0]        byte_cnt_q, byte_cnt_d;
  logic              overrun_q, overrun_d;

  logic load, shift, capture;
  logic byte_valid, bit_out, last_bit, drop;
  logic img_done;
  logic ram_we, ram_sel, core_start;

  byte_unpacker u_unpack (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy_i    (bus.rx_rdy),
    .rx_data_i   (bus.rx_data),
    .load_i      (load),
    .shift_i     (shift),
    .capture_i   (capture),
    .byte_valid_o(byte_valid),
    .bit_out_o   (bit_out),
    .last_bit_o  (last_bit),
    .drop_o      (drop)
  );

  // Final write of the image; forces START so no counter can wrap.
  assign img_done = (state_q == UNPACK) && (pix_cnt_q == LAST_PIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      byte_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    byte_cnt_d = byte_cnt_q;
    overrun_d  = overrun_q | drop;
    unique case (state_q)
      IDLE: if (byte_valid) state_d = UNPACK;
      UNPACK: begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        if (last_bit) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
          if (img_done) begin
            state_d    = START;
            pix_cnt_d  = '0;
            byte_cnt_d = '0;
          end else if (!byte_valid) begin
            state_d = IDLE;
          end
        end
      end
      START:     state_d = WAIT_CORE;
      WAIT_CORE: if (bus.core_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    load       = 1'b0;
    shift      = 1'b0;
    capture    = 1'b0;
    ram_we     = 1'b0;
    ram_sel    = 1'b0;
    core_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        load    = byte_valid;
        capture = 1'b1;
        ram_sel = 1'b1;
      end
      UNPACK: begin
        shift   = 1'b1;
        capture = 1'b1;
        ram_we  = 1'b1;
        ram_sel = 1'b1;
        load    = last_bit & byte_valid & ~img_done;
      end
      START:   core_start = 1'b1;
      default: ;
    endcase
  end

  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = pix_cnt_q;
  assign bus.ram_wdata  = ram_we & bit_out;
  assign bus.ram_sel    = ram_sel;
  assign bus.core_start = core_start;
  assign bus.busy       = (state_q != IDLE) || (byte_cnt_q != 7'd0);
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_snn_image_loader.sv
// Bench for snn_image_loader: vector table, directed corner cases, random image vs model.
module tb_snn_image_loader;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  snn_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

  snn_image_loader #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; int d; } wr_t;
  typedef struct { logic [7:0] data; logic [7:0] order; } vec_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  cs_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (bus.ram_we) begin
      w.cyc = cyc; w.addr = int'(bus.ram_addr); w.d = int'(bus.ram_wdata);
      act_q.push_back(w);
    end
    if (bus.core_start) cs_q.push_back(cyc);
  end

  // Transaction-level model: each accepted byte occupies 8 write cycles starting
  // the cycle after arrival or right after the previous byte, whichever is later.
  int m_acc, m_last_end, m_prev_end, m_cs;
  bit m_lock, m_ovr;

  function automatic void m_reset();
    m_acc = 0; m_last_end = -100; m_prev_end = -100;
    m_lock = 0; m_ovr = 0; m_cs = -1;
  endfunction

  function automatic void m_rx(int t, logic [7:0] b);
    int start;
    wr_t w;
    if (m_lock || m_prev_end > t) begin
      m_ovr = 1;
      return;
    end
    start = (t + 1 > m_last_end + 1) ? t + 1 : m_last_end + 1;
    for (int k = 0; k < 8; k++) begin
      w.cyc = start + k; w.addr = m_acc * 8 + k; w.d = int'(b[k]);
      exp_q.push_back(w);
    end
    m_prev_end = m_last_end;
    m_last_end = start + 7;
    m_acc++;
    if (m_acc == NUM_BYTES) begin
      m_lock = 1;
      m_cs = m_last_end + 1;
    end
  endfunction

  function automatic void m_done();
    if (m_lock) begin
      m_lock = 0; m_acc = 0; m_last_end = -100; m_prev_end = -100;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_rdy = 1'b1;
    bus.rx_data = b;
    m_rx(cyc, b);
    @(negedge clk);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ram_we"},     int'(bus.ram_we), 0);
    chk({tag, " ram_addr"},   int'(bus.ram_addr), 0);
    chk({tag, " ram_wdata"},  int'(bus.ram_wdata), 0);
    chk({tag, " ram_sel"},    int'(bus.ram_sel), 1);
    chk({tag, " core_start"}, int'(bus.core_start), 0);
    chk({tag, " busy"},       int'(bus.busy), 0);
    chk({tag, " overrun"},    int'(bus.overrun), 0);
  endtask

  task automatic do_reset(input bit check, input string tag);
    #2 rst_n = 1'b0;
    bus.rx_rdy = 1'b0;
    bus.core_done = 1'b0;
    #1 if (check) chk_reset_vals(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    exp_q.delete(); act_q.delete(); cs_q.delete();
  endtask

  task automatic compare_writes(input string name);
    int bad = 0;
    int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (act_q[i].cyc != exp_q[i].cyc || act_q[i].addr != exp_q[i].addr || act_q[i].d != exp_q[i].d)
        bad++;
    chk({name, " write count"}, act_q.size(), exp_q.size());
    chk({name, " bad writes"}, bad, 0);
  endtask

  task automatic wait_cs(input string name);
    for (int i = 0; i < 60 && cs_q.size() == 0; i++) @(negedge clk);
    chk({name, " core_start seen"}, cs_q.size(), 1);
  endtask

  function automatic int ones();
    int s = 0;
    foreach (act_q[i]) s += act_q[i].d;
    return s;
  endfunction

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ord;
    int addr_bad;
    int last_t;
    int iter;

    vecs[0] = '{8'hA5, 8'b10100101};
    vecs[1] = '{8'h01, 8'b10000000};
    vecs[2] = '{8'h80, 8'b00000001};
    vecs[3] = '{8'h3C, 8'b00111100};
    vecs[4] = '{8'h0D, 8'b10110000};

    bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.core_done = 1'b0;
    m_reset();
    @(negedge clk);
    do_reset(1, "reset");

    // Single bytes after reset: write order and address sequence from the table.
    for (int i = 0; i < 5; i++) begin
      do_reset(0, "");
      send(vecs[i].data);
      tick(12);
      ord = '0; addr_bad = 0;
      for (int k = 0; k < 8 && k < act_q.size(); k++) begin
        ord[7-k] = act_q[k].d[0];
        if (act_q[k].addr != k) addr_bad++;
      end
      chk($sformatf("vec%0d writes", i), act_q.size(), 8);
      chk($sformatf("vec%0d data order", i), int'(ord), int'(vecs[i].order));
      chk($sformatf("vec%0d addr bad", i), addr_bad, 0);
      chk($sformatf("vec%0d core_start", i), cs_q.size(), 0);
      chk($sformatf("vec%0d busy", i), int'(bus.busy), 1);
      if (i == 0) begin
        bus.core_done = 1'b1; m_done();
        @(negedge clk);
        bus.core_done = 1'b0;
        send(8'h0F);
        tick(12);
        compare_writes("idle core_done ignored");
        chk("idle core_done busy", int'(bus.busy), 1);
      end
    end

    // Two bytes two cycles apart: buffered, contiguous 16 writes.
    do_reset(0, "");
    send(8'h01); tick(1); send(8'h80); tick(20);
    compare_writes("b2b");
    chk("b2b ones", ones(), 2);
    if (act_q.size() == 16) begin
      chk("b2b addr0 data", act_q[0].d, 1);
      chk("b2b addr15 data", act_q[15].d, 1);
      chk("b2b span", act_q[15].cyc - act_q[0].cyc, 15);
    end
    chk("b2b overrun", int'(bus.overrun), 0);

    // Three pulses in three cycles: third byte dropped.
    do_reset(0, "");
    send(8'h11); send(8'h22); send(8'h33); tick(25);
    chk("triple overrun", int'(bus.overrun), 1);
    chk("triple writes", act_q.size(), 16);
    compare_writes("triple");

    // Full image of 0xFF, spaced 20 cycles.
    do_reset(0, "");
    last_t = 0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      last_t = cyc;
      send(8'hFF);
      tick(19);
    end
    wait_cs("image");
    if (cs_q.size() > 0) chk("image start latency", cs_q[0] - last_t, 9);
    compare_writes("image");
    chk("image ones", ones(), NUM_PIX);
    chk("image ram_sel", int'(bus.ram_sel), 0);
    chk("image busy", int'(bus.busy), 1);
    send(8'h5A);
    tick(10);
    chk("wait_core overrun", int'(bus.overrun), 1);
    chk("wait_core no write", act_q.size(), NUM_PIX);
    bus.core_done = 1'b1; m_done();
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("done ram_sel", int'(bus.ram_sel), 1);
    chk("done busy", int'(bus.busy), 0);
    act_q.delete(); exp_q.delete(); cs_q.delete();
    send(8'h81);
    tick(10);
    compare_writes("next image");
    if (act_q.size() > 0) chk("next image addr0", act_q[0].addr, 0);
    chk("next image start count", cs_q.size(), 0);

    // Async reset mid-image.
    do_reset(0, "");
    for (int b = 0; b < 40; b++) begin
      send(8'($urandom));
      tick(9);
    end
    compare_writes("40 bytes");
    send(8'hE7);
    tick(3);
    do_reset(1, "mid reset");
    send(8'hC3);
    tick(10);
    compare_writes("post reset");
    if (act_q.size() > 0) chk("post reset addr0", act_q[0].addr, 0);

    // Random gaps, random data, one full image against the model.
    do_reset(0, "");
    iter = 0;
    while (!m_lock && iter < 2000) begin
      tick($urandom_range(0, 9));
      send(8'($urandom));
      iter++;
    end
    wait_cs("rand");
    if (cs_q.size() > 0) chk("rand start cycle", cs_q[0], m_cs);
    compare_writes("rand");
    chk("rand overrun", int'(bus.overrun), int'(m_ovr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
